// File: rtl/serial_parity_checker_if.sv
// Handshake bundle for the parity-checked serial receiver.
// slave = checker side, master = link/consumer side.
interface serial_parity_checker_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_bit;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] data;
   logic             parity_err;
   logic             red_and;
   logic             red_or;
   logic             red_xor;
   logic [7:0]       err_count;

   modport master (
      output in_valid,
      output in_bit,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  data,
      input  parity_err,
      input  red_and,
      input  red_or,
      input  red_xor,
      input  err_count
   );

   modport slave (
      input  in_valid,
      input  in_bit,
      input  out_ready,
      output in_ready,
      output out_valid,
      output data,
      output parity_err,
      output red_and,
      output red_or,
      output red_xor,
      output err_count
   );
endinterface

// File: rtl/serial_parity_checker.sv
// Serial frame receiver: WIDTH bits LSB first, then parity, word out.
// Define PARITY_ERR_COUNT_EN for the saturating parity-error counter.
module serial_parity_checker #(
   parameter int WIDTH      = 4,
   parameter bit ODD_PARITY = 1'b0
) (
   input logic                   clk,
   input logic                   rst,
   serial_parity_checker_if.slave bus
);
   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      RECV = 2'd0,
      PAR  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [CW-1:0]    cnt_q;
   logic             runxor_q;
   logic [WIDTH-1:0] sh_q;
   logic [WIDTH-1:0] data_q;
   logic             err_q;
   logic             and_q;
   logic             or_q;
   logic             xor_q;
   logic             in_ready;
   logic             out_valid;
   logic             acc;
   logic             par_bad;

   assign acc     = bus.in_valid && in_ready;
   assign par_bad = (runxor_q ^ bus.in_bit) != ODD_PARITY;

   always_ff @(posedge clk) begin
      if (rst) state_q <= RECV;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RECV:    if (acc && cnt_q == LAST) state_d = PAR;
         PAR:     if (acc) state_d = HOLD;
         HOLD:    if (bus.out_ready) state_d = RECV;
         default: state_d = RECV;
      endcase
   end

   always_comb begin
      in_ready  = 1'b1;
      out_valid = 1'b0;
      unique case (1'b1)
         (state_q == HOLD): begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
         end
         default: ;
      endcase
   end

   // Bits collect in a shadow register so the presented word stays
   // untouched while the next frame is arriving.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         runxor_q <= 1'b0;
         sh_q     <= '0;
      end else if (state_q == RECV && acc) begin
         sh_q[cnt_q] <= bus.in_bit;
         runxor_q    <= runxor_q ^ bus.in_bit;
         if (cnt_q != LAST) cnt_q <= cnt_q + CW'(1);
      end else if (state_q == HOLD && bus.out_ready) begin
         cnt_q    <= '0;
         runxor_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         err_q  <= 1'b0;
         and_q  <= 1'b0;
         or_q   <= 1'b0;
         xor_q  <= 1'b0;
      end else if (state_q == PAR && acc) begin
         data_q <= sh_q;
         err_q  <= par_bad;
         and_q  <= &sh_q;
         or_q   <= |sh_q;
         xor_q  <= ^sh_q;
      end
   end

`ifdef PARITY_ERR_COUNT_EN
   logic [7:0] cnt_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_err_q <= '0;
      end else if (state_q == PAR && acc && par_bad) begin
         if (cnt_err_q != 8'd255) cnt_err_q <= cnt_err_q + 8'd1;
      end
   end

   assign bus.err_count = cnt_err_q;
`else
   assign bus.err_count = 8'd0;
`endif

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid;
   assign bus.data       = data_q;
   assign bus.parity_err = err_q;
   assign bus.red_and    = and_q;
   assign bus.red_or     = or_q;
   assign bus.red_xor    = xor_q;
endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker, WIDTH=4, even parity.
// Honours PARITY_ERR_COUNT_EN for the error-counter expectations.
module tb_serial_parity_checker;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   logic [7:0] exp_cnt = 8'd0;

   serial_parity_checker_if #(.WIDTH(4)) bus ();

   serial_parity_checker #(
      .WIDTH(4),
      .ODD_PARITY(1'b0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic note_err();
`ifdef PARITY_ERR_COUNT_EN
      if (exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
`endif
   endtask

   task automatic send_bit(input logic b);
      int n = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_bit   = b;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n >= 20) begin
         $display("FAIL send_bit_timeout in_ready=%b want=1", bus.in_ready);
         bad++;
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [3:0] d, input logic p);
      for (int i = 0; i < 4; i++) send_bit(d[i]);
      send_bit(p);
   endtask

   task automatic retire();
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = 8'd0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         $display("FAIL reset_hs valid=%b ready=%b want 0/1",
                  bus.out_valid, bus.in_ready);
         bad++;
      end
      total++;
      if (bus.data !== 4'h0 || bus.parity_err !== 1'b0) begin
         $display("FAIL reset_data data=%h err=%b want 0/0",
                  bus.data, bus.parity_err);
         bad++;
      end
      total++;
      if ({bus.red_and, bus.red_or, bus.red_xor} !== 3'b000) begin
         $display("FAIL reset_red got=%b want=000",
                  {bus.red_and, bus.red_or, bus.red_xor});
         bad++;
      end
      total++;
      if (bus.err_count !== 8'd0) begin
         $display("FAIL reset_cnt got=%0d want=0", bus.err_count);
         bad++;
      end
   endtask

   task automatic test_basic();
      send_frame(4'b0101, 1'b0);
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1) begin
         $display("FAIL basic_latency out_valid=%b want=1", bus.out_valid);
         bad++;
      end
      total++;
      if (bus.data !== 4'b0101 || bus.parity_err !== 1'b0) begin
         $display("FAIL basic_data data=%b err=%b want 0101/0",
                  bus.data, bus.parity_err);
         bad++;
      end
      total++;
      if ({bus.red_and, bus.red_or, bus.red_xor} !== 3'b010) begin
         $display("FAIL basic_red got=%b want=010",
                  {bus.red_and, bus.red_or, bus.red_xor});
         bad++;
      end
      retire();
   endtask

   task automatic test_parity_err();
      send_frame(4'b0101, 1'b1);
      note_err();
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.parity_err !== 1'b1) begin
         $display("FAIL perr_flag valid=%b err=%b want 1/1",
                  bus.out_valid, bus.parity_err);
         bad++;
      end
      total++;
      if (bus.err_count !== exp_cnt) begin
         $display("FAIL perr_cnt got=%0d want=%0d", bus.err_count, exp_cnt);
         bad++;
      end
      retire();
   endtask

   task automatic test_patterns();
      send_frame(4'b1111, 1'b0);
      @(negedge clk);
      total++;
      if (bus.data !== 4'hF || bus.parity_err !== 1'b0 ||
          {bus.red_and, bus.red_or, bus.red_xor} !== 3'b110) begin
         $display("FAIL ones data=%h err=%b red=%b want f/0/110", bus.data,
                  bus.parity_err, {bus.red_and, bus.red_or, bus.red_xor});
         bad++;
      end
      retire();
      send_frame(4'b0000, 1'b0);
      @(negedge clk);
      total++;
      if (bus.data !== 4'h0 || bus.parity_err !== 1'b0 ||
          {bus.red_and, bus.red_or, bus.red_xor} !== 3'b000) begin
         $display("FAIL zeros data=%h err=%b red=%b want 0/0/000", bus.data,
                  bus.parity_err, {bus.red_and, bus.red_or, bus.red_xor});
         bad++;
      end
      retire();
      // odd weight with matching parity bit
      send_frame(4'b0001, 1'b1);
      @(negedge clk);
      total++;
      if (bus.data !== 4'h1 || bus.parity_err !== 1'b0 ||
          {bus.red_and, bus.red_or, bus.red_xor} !== 3'b011) begin
         $display("FAIL oddw data=%h err=%b red=%b want 1/0/011", bus.data,
                  bus.parity_err, {bus.red_and, bus.red_or, bus.red_xor});
         bad++;
      end
      retire();
   endtask

   task automatic test_hold();
      send_frame(4'b1001, 1'b0);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_bit   = 1'b1;
         total++;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
             bus.data !== 4'b1001 || bus.parity_err !== 1'b0) begin
            $display("FAIL hold_%0d rdy=%b vld=%b data=%b err=%b want 0/1/1001/0",
                     i, bus.in_ready, bus.out_valid, bus.data, bus.parity_err);
            bad++;
         end
      end
      bus.in_valid = 1'b0;
      retire();
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         $display("FAIL hold_release rdy=%b vld=%b want 1/0",
                  bus.in_ready, bus.out_valid);
         bad++;
      end
      send_frame(4'b0011, 1'b0);
      @(negedge clk);
      total++;
      if (bus.data !== 4'b0011 || bus.parity_err !== 1'b0) begin
         $display("FAIL hold_next data=%b err=%b want 0011/0",
                  bus.data, bus.parity_err);
         bad++;
      end
      retire();
   endtask

   task automatic test_back_to_back();
      send_frame(4'b1010, 1'b0);
      retire();
      send_bit(1'b1);
      send_bit(1'b1);
      @(negedge clk);
      total++;
      if (bus.data !== 4'b1010 || bus.out_valid !== 1'b0) begin
         $display("FAIL b2b_stable data=%b vld=%b want 1010/0",
                  bus.data, bus.out_valid);
         bad++;
      end
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      @(negedge clk);
      total++;
      if (bus.data !== 4'b0111 || bus.parity_err !== 1'b1) begin
         $display("FAIL b2b_second data=%b err=%b want 0111/1",
                  bus.data, bus.parity_err);
         bad++;
      end
      note_err();
      retire();
   endtask

   task automatic test_rst_mid();
      send_bit(1'b1);
      send_bit(1'b1);
      do_reset();
      send_frame(4'b0110, 1'b0);
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.data !== 4'b0110 ||
          bus.parity_err !== 1'b0) begin
         $display("FAIL rst_mid vld=%b data=%b err=%b want 1/0110/0",
                  bus.out_valid, bus.data, bus.parity_err);
         bad++;
      end
      do_reset();
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
          bus.data !== 4'h0) begin
         $display("FAIL rst_hold vld=%b rdy=%b data=%h want 0/1/0",
                  bus.out_valid, bus.in_ready, bus.data);
         bad++;
      end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 260; i++) begin
         send_frame(4'b0001, 1'b0);
         note_err();
         retire();
         if (i == 2) begin
            @(negedge clk);
            total++;
            if (bus.err_count !== exp_cnt) begin
               $display("FAIL cnt_early got=%0d want=%0d",
                        bus.err_count, exp_cnt);
               bad++;
            end
         end
      end
      @(negedge clk);
      total++;
      if (bus.err_count !== exp_cnt) begin
         $display("FAIL cnt_sat got=%0d want=%0d", bus.err_count, exp_cnt);
         bad++;
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_bit    = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_parity_err();
      test_patterns();
      test_hold();
      test_back_to_back();
      test_rst_mid();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
